// File: rtl/rs_mult_div_pkg.sv
// Shared types for the multiply/divide reservation station: decoded control,
// station entry layout, issue payload and source-operand resolution at dispatch.
package rs_mult_div_pkg;

  localparam int RS_PHYS_REG_BITS = 6;
  localparam int RS_ROB_IDX_BITS  = 4;
  localparam int RS_NUM_ENTRIES   = 4;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } decode_info_t;

  typedef struct packed {
    logic                        valid;
    decode_info_t                info;
    logic [RS_PHYS_REG_BITS-1:0] rs1_paddr;
    logic [RS_PHYS_REG_BITS-1:0] rs2_paddr;
    logic                        rs1_rdy;
    logic                        rs2_rdy;
    logic [31:0]                 rs1_v;
    logic [31:0]                 rs2_v;
    logic [RS_PHYS_REG_BITS-1:0] rd_paddr;
    logic [RS_ROB_IDX_BITS-1:0]  rob_idx;
  } rs_md_entry_t;

  typedef struct packed {
    decode_info_t                info;
    logic [31:0]                 rs1_v;
    logic [31:0]                 rs2_v;
    logic [RS_PHYS_REG_BITS-1:0] rd_paddr;
    logic [RS_ROB_IDX_BITS-1:0]  rob_idx;
  } rs_md_issue_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] v;
  } src_t;

  // x0 reads as zero and is always ready; a matching broadcast in the dispatch
  // cycle supplies the value directly.
  function automatic src_t resolve_src(
    input logic [RS_PHYS_REG_BITS-1:0] tag,
    input logic                        rdy,
    input logic [31:0]                 v,
    input logic                        cdb_hit,
    input logic [RS_PHYS_REG_BITS-1:0] cdb_tag,
    input logic [31:0]                 cdb_v
  );
    src_t s;
    s.rdy = 1'b1;
    s.v   = v;
    if (!rdy) begin
      if (tag == '0) begin
        s.v = '0;
      end else if (cdb_hit && (tag == cdb_tag)) begin
        s.v = cdb_v;
      end else begin
        s.rdy = 1'b0;
        s.v   = '0;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/rs_mult_div_age.sv
// Age matrix: older_q[i][j] set means entry i was allocated before entry j.
// Grants the single ready entry that no other ready entry is older than.
module rs_age_matrix #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ENTRIES-1:0] alloc_i,
  input  logic [NUM_ENTRIES-1:0] free_i,
  input  logic [NUM_ENTRIES-1:0] ready_i,
  output logic [NUM_ENTRIES-1:0] grant_o
);

  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (free_i[i]) older_d[i] = '0;
    end
    // A new entry is younger than every other slot.
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (alloc_i[k]) begin
        older_d[k] = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (i != k) older_d[i][k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      grant_o[i] = ready_i[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if ((j != i) && ready_i[j] && older_q[j][i]) grant_o[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) older_q <= '0;
    else     older_q <= older_d;
  end

endmodule

// File: rtl/rs_mult_div.sv
// Reservation station for the mult/div unit: dispatch into the lowest free slot,
// CDB wakeup, oldest-ready select and a registered valid/ready issue stage.
// Handshake: a uop transfers to the FU on a rising edge where issue_valid && issue_ready;
// while issue_valid && !issue_ready the payload and issue_valid stay unchanged.
module rs_mult_div
  import rs_mult_div_pkg::*;
#(
  parameter int PHYS_REG_BITS = RS_PHYS_REG_BITS,
  parameter int ROB_IDX_BITS  = RS_ROB_IDX_BITS,
  parameter int NUM_ENTRIES   = RS_NUM_ENTRIES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  decode_info_t             dispatch_info,
  input  logic [PHYS_REG_BITS-1:0] dispatch_rs1_paddr,
  input  logic [PHYS_REG_BITS-1:0] dispatch_rs2_paddr,
  input  logic                     dispatch_rs1_rdy,
  input  logic                     dispatch_rs2_rdy,
  input  logic [31:0]              dispatch_rs1_v,
  input  logic [31:0]              dispatch_rs2_v,
  input  logic [PHYS_REG_BITS-1:0] dispatch_rd_paddr,
  input  logic [ROB_IDX_BITS-1:0]  dispatch_rob_idx,
  input  logic                     cdb_valid,
  input  logic [PHYS_REG_BITS-1:0] cdb_paddr,
  input  logic [31:0]              cdb_data,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output decode_info_t             decode_info,
  output logic [31:0]              rs1_v,
  output logic [31:0]              rs2_v,
  output logic [PHYS_REG_BITS-1:0] rd_paddr,
  output logic [ROB_IDX_BITS-1:0]  rob_idx
);

  rs_md_entry_t entries_q [NUM_ENTRIES];
  rs_md_entry_t entries_d [NUM_ENTRIES];
  rs_md_entry_t new_entry, sel_entry;
  rs_md_issue_t out_q, out_d;
  logic         issue_valid_q, issue_valid_d;

  logic [NUM_ENTRIES-1:0] free_vec, ready_vec, alloc_oh, grant;
  logic                   cdb_hit, disp_fire, load;
  src_t                   src1, src2;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i]  = !entries_q[i].valid;
      ready_vec[i] = entries_q[i].valid && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
    end
  end

  // Lowest set bit of the free vector picks the dispatch slot.
  assign alloc_oh       = free_vec & (~free_vec + NUM_ENTRIES'(1));
  assign dispatch_ready = |free_vec;
  assign cdb_hit        = cdb_valid && (cdb_paddr != '0);
  assign disp_fire      = dispatch_valid && dispatch_ready && !flush;
  assign load           = (|grant) && (!issue_valid_q || issue_ready) && !flush;

  rs_age_matrix #(.NUM_ENTRIES(NUM_ENTRIES)) u_age (
    .clk     (clk),
    .rst     (rst),
    .alloc_i (disp_fire ? alloc_oh : '0),
    .free_i  (load ? grant : '0),
    .ready_i (ready_vec),
    .grant_o (grant)
  );

  always_comb begin
    src1 = resolve_src(dispatch_rs1_paddr, dispatch_rs1_rdy, dispatch_rs1_v,
                       cdb_hit, cdb_paddr, cdb_data);
    src2 = resolve_src(dispatch_rs2_paddr, dispatch_rs2_rdy, dispatch_rs2_v,
                       cdb_hit, cdb_paddr, cdb_data);
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.info      = dispatch_info;
    new_entry.rs1_paddr = dispatch_rs1_paddr;
    new_entry.rs2_paddr = dispatch_rs2_paddr;
    new_entry.rs1_rdy   = src1.rdy;
    new_entry.rs2_rdy   = src2.rdy;
    new_entry.rs1_v     = src1.v;
    new_entry.rs2_v     = src2.v;
    new_entry.rd_paddr  = dispatch_rd_paddr;
    new_entry.rob_idx   = dispatch_rob_idx;
  end

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (grant[i]) sel_entry = entries_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (cdb_hit && entries_q[i].valid) begin
        if (!entries_q[i].rs1_rdy && (entries_q[i].rs1_paddr == cdb_paddr)) begin
          entries_d[i].rs1_rdy = 1'b1;
          entries_d[i].rs1_v   = cdb_data;
        end
        if (!entries_q[i].rs2_rdy && (entries_q[i].rs2_paddr == cdb_paddr)) begin
          entries_d[i].rs2_rdy = 1'b1;
          entries_d[i].rs2_v   = cdb_data;
        end
      end
      if (load && grant[i])        entries_d[i].valid = 1'b0;
      if (disp_fire && alloc_oh[i]) entries_d[i]       = new_entry;
      if (flush)                   entries_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q && !issue_ready;
    out_d         = out_q;
    if (load) begin
      issue_valid_d  = 1'b1;
      out_d.info     = sel_entry.info;
      out_d.rs1_v    = sel_entry.rs1_v;
      out_d.rs2_v    = sel_entry.rs2_v;
      out_d.rd_paddr = sel_entry.rd_paddr;
      out_d.rob_idx  = sel_entry.rob_idx;
    end
    if (flush) issue_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= '0;
      issue_valid_q <= 1'b0;
      out_q         <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= entries_d[i];
      issue_valid_q <= issue_valid_d;
      out_q         <= out_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign decode_info = out_q.info;
  assign rs1_v       = out_q.rs1_v;
  assign rs2_v       = out_q.rs2_v;
  assign rd_paddr    = out_q.rd_paddr;
  assign rob_idx     = out_q.rob_idx;

endmodule

// File: tb/tb_rs_mult_div.sv
// Directed bench for rs_mult_div: expected issue payloads are queued at dispatch
// and popped by a monitor on every FU handshake.
module tb_rs_mult_div;
  import rs_mult_div_pkg::*;

  localparam int P = 6;
  localparam int R = 4;
  localparam int W = $bits(decode_info_t) + 64 + P + R;

  logic         clk, rst, flush;
  logic         dispatch_valid, dispatch_ready;
  decode_info_t dispatch_info;
  logic [P-1:0] dispatch_rs1_paddr, dispatch_rs2_paddr, dispatch_rd_paddr;
  logic         dispatch_rs1_rdy, dispatch_rs2_rdy;
  logic [31:0]  dispatch_rs1_v, dispatch_rs2_v;
  logic [R-1:0] dispatch_rob_idx;
  logic         cdb_valid;
  logic [P-1:0] cdb_paddr;
  logic [31:0]  cdb_data;
  logic         issue_valid, issue_ready;
  decode_info_t decode_info;
  logic [31:0]  rs1_v, rs2_v;
  logic [P-1:0] rd_paddr;
  logic [R-1:0] rob_idx;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  rs_mult_div dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_info(dispatch_info),
    .dispatch_rs1_paddr(dispatch_rs1_paddr), .dispatch_rs2_paddr(dispatch_rs2_paddr),
    .dispatch_rs1_rdy(dispatch_rs1_rdy), .dispatch_rs2_rdy(dispatch_rs2_rdy),
    .dispatch_rs1_v(dispatch_rs1_v), .dispatch_rs2_v(dispatch_rs2_v),
    .dispatch_rd_paddr(dispatch_rd_paddr), .dispatch_rob_idx(dispatch_rob_idx),
    .cdb_valid(cdb_valid), .cdb_paddr(cdb_paddr), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .decode_info(decode_info), .rs1_v(rs1_v), .rs2_v(rs2_v),
    .rd_paddr(rd_paddr), .rob_idx(rob_idx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack_uop(input decode_info_t info, input logic [31:0] a,
                                            input logic [31:0] b, input logic [P-1:0] rd,
                                            input logic [R-1:0] rob);
    return {info, a, b, rd, rob};
  endfunction

  function automatic decode_info_t md_info(input logic [2:0] f3);
    decode_info_t d;
    d.opcode = 7'b0110011;
    d.funct3 = f3;
    d.funct7 = 7'b0000001;
    return d;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic dispatch_uop(input logic [2:0] f3,
                              input logic [P-1:0] t1, input logic r1, input logic [31:0] v1,
                              input logic [P-1:0] t2, input logic r2, input logic [31:0] v2,
                              input logic [P-1:0] rd, input logic [R-1:0] rob,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input bit expect_issue);
    logic acc;
    dispatch_valid     = 1'b1;
    dispatch_info      = md_info(f3);
    dispatch_rs1_paddr = t1;
    dispatch_rs1_rdy   = r1;
    dispatch_rs1_v     = v1;
    dispatch_rs2_paddr = t2;
    dispatch_rs2_rdy   = r2;
    dispatch_rs2_v     = v2;
    dispatch_rd_paddr  = rd;
    dispatch_rob_idx   = rob;
    acc = dispatch_ready;
    if (acc && expect_issue) exp_q.push_back(pack_uop(md_info(f3), e1, e2, rd, rob));
    tick();
    dispatch_valid = 1'b0;
  endtask

  task automatic broadcast(input logic [P-1:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_paddr = tag;
    cdb_data  = data;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL %s: observed %0d uops still unissued, expected 0", tag, exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL spurious_issue: observed rob %0d rs1 %h rs2 %h, expected no issue",
               rob_idx, rs1_v, rs2_v);
      end
      if (exp_q.size() != 0) begin
        vectors--;
        check("issue_payload", pack_uop(decode_info, rs1_v, rs2_v, rd_paddr, rob_idx),
              exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    logic [31:0] a, b;
    rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_info = '0;
    dispatch_rs1_paddr = '0; dispatch_rs2_paddr = '0; dispatch_rs1_rdy = 1'b0;
    dispatch_rs2_rdy = 1'b0; dispatch_rs1_v = '0; dispatch_rs2_v = '0;
    dispatch_rd_paddr = '0; dispatch_rob_idx = '0;
    cdb_valid = 1'b0; cdb_paddr = '0; cdb_data = '0; issue_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check_bit("reset_issue_valid", issue_valid, 1'b0);
    check_bit("reset_dispatch_ready", dispatch_ready, 1'b1);
    check("reset_payload", pack_uop(decode_info, rs1_v, rs2_v, rd_paddr, rob_idx), '0);

    // 1: mul 3*8, both ready
    issue_ready = 1'b1;
    dispatch_uop(3'b000, 6'd1, 1'b1, 32'd3, 6'd2, 1'b1, 32'd8, 6'd10, 4'd1, 32'd3, 32'd8, 1);
    wait_drain("t1_mul_ready");

    // 2: wakeup of rs1 by a later broadcast, nothing issued before it
    dispatch_uop(3'b001, 6'd5, 1'b0, 32'hDEAD, 6'd3, 1'b1, 32'd7, 6'd11, 4'd2,
                 32'h10, 32'd7, 1);
    for (int i = 0; i < 3; i++) begin
      check_bit("t2_no_early_issue", issue_valid, 1'b0);
      tick();
    end
    broadcast(6'd5, 32'h10);
    wait_drain("t2_wakeup");

    // 3: same-cycle bypass on rs2
    cdb_valid = 1'b1; cdb_paddr = 6'd9; cdb_data = 32'hABCD;
    dispatch_uop(3'b100, 6'd4, 1'b1, 32'd100, 6'd9, 1'b0, 32'd0, 6'd12, 4'd3,
                 32'd100, 32'hABCD, 1);
    cdb_valid = 1'b0;
    wait_drain("t3_bypass");

    // 3b: both sources woken by one broadcast
    dispatch_uop(3'b101, 6'd14, 1'b0, 32'd0, 6'd14, 1'b0, 32'd0, 6'd13, 4'd4,
                 32'h55, 32'h55, 1);
    tick();
    broadcast(6'd14, 32'h55);
    wait_drain("t3_dual_wakeup");

    // 4: backpressure, full station, age order across reused slots
    issue_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 10 && dispatch_ready; i++) begin
      a = $urandom_range(0, 32'hFFFF);
      b = $urandom_range(1, 32'hFFFF);
      dispatch_uop(3'($urandom_range(0, 7)), 6'd30, 1'b1, a, 6'd31, 1'b1, b,
                   6'(16 + k), 4'(k), a, b, 1);
      k++;
    end
    vectors++;
    assert (k == 5) else begin
      miscompares++;
      $error("FAIL t4_fill_count: observed %0d accepted, expected 5", k);
    end
    check_bit("t4_full_not_ready", dispatch_ready, 1'b0);
    check_bit("t4_stage_valid", issue_valid, 1'b1);
    check("t4_stage_rob0", {{(W-R){1'b0}}, rob_idx}, {{(W-R){1'b0}}, 4'd0});
    dispatch_uop(3'b000, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1, 6'd1, 4'd9, 32'd1, 32'd1, 0);
    tick();
    check_bit("t4_hold_valid", issue_valid, 1'b1);
    check("t4_hold_rob0", {{(W-R){1'b0}}, rob_idx}, {{(W-R){1'b0}}, 4'd0});
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_bit("t4_back_to_back", issue_valid, 1'b1);
      tick();
    end
    wait_drain("t4_drain");

    // 5: flush with pending entries and a loaded stage
    issue_ready = 1'b0;
    dispatch_uop(3'b000, 6'd1, 1'b1, 32'd6, 6'd2, 1'b1, 32'd6, 6'd20, 4'd6, 32'd6, 32'd6, 0);
    dispatch_uop(3'b000, 6'd20, 1'b0, 32'd0, 6'd2, 1'b1, 32'd1, 6'd21, 4'd7, 32'd0, 32'd0, 0);
    dispatch_uop(3'b000, 6'd21, 1'b0, 32'd0, 6'd2, 1'b1, 32'd1, 6'd22, 4'd8, 32'd0, 32'd0, 0);
    dispatch_uop(3'b000, 6'd22, 1'b0, 32'd0, 6'd2, 1'b1, 32'd1, 6'd23, 4'd9, 32'd0, 32'd0, 0);
    check_bit("t5_stage_loaded", issue_valid, 1'b1);
    flush = 1'b1;
    dispatch_uop(3'b000, 6'd1, 1'b1, 32'd2, 6'd2, 1'b1, 32'd2, 6'd24, 4'd10, 32'd2, 32'd2, 0);
    flush = 1'b0;
    check_bit("t5_flush_issue_valid", issue_valid, 1'b0);
    check_bit("t5_flush_dispatch_ready", dispatch_ready, 1'b1);
    issue_ready = 1'b1;
    broadcast(6'd20, 32'h20);
    broadcast(6'd21, 32'h21);
    broadcast(6'd22, 32'h22);
    repeat (4) tick();
    check_bit("t5_no_stale_issue", issue_valid, 1'b0);

    // 6: x0 is ready with value 0; a tag-0 broadcast wakes nothing
    dispatch_uop(3'b110, 6'd0, 1'b0, 32'h1234, 6'd2, 1'b1, 32'd5, 6'd25, 4'd11,
                 32'd0, 32'd5, 1);
    wait_drain("t6_x0_ready");
    dispatch_uop(3'b111, 6'd7, 1'b0, 32'd0, 6'd0, 1'b0, 32'h999, 6'd26, 4'd12,
                 32'h77, 32'd0, 1);
    broadcast(6'd0, 32'hDEAD);
    tick();
    check_bit("t6_tag0_no_wake", issue_valid, 1'b0);
    broadcast(6'd7, 32'h77);
    wait_drain("t6_tag7_wakeup");

    // 7: reset mid-operation
    issue_ready = 1'b0;
    dispatch_uop(3'b000, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd9, 6'd27, 4'd13, 32'd9, 32'd9, 0);
    dispatch_uop(3'b000, 6'd40, 1'b0, 32'd0, 6'd2, 1'b1, 32'd1, 6'd28, 4'd14, 32'd0, 32'd0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bit("t7_reset_issue_valid", issue_valid, 1'b0);
    check_bit("t7_reset_dispatch_ready", dispatch_ready, 1'b1);
    check("t7_reset_payload", pack_uop(decode_info, rs1_v, rs2_v, rd_paddr, rob_idx), '0);
    issue_ready = 1'b1;
    broadcast(6'd40, 32'h40);
    repeat (4) tick();
    check_bit("t7_no_issue_after_reset", issue_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
